// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle logical barrel-free shifter, one bit per cycle.
//   clk       - clock, all state updates on rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - request on a/dir/amt is valid
//   in_ready  - block can accept a request (IDLE only)
//   a         - operand, WIDTH bits
//   dir       - 0 = shift left, 1 = shift right
//   amt       - shift amount, 0..WIDTH-1
//   out_valid - y holds a finished result (DONE only)
//   out_ready - consumer takes y
//   y         - shifted result
//   busy      - state is not IDLE
module seq_shifter #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic             dir,
   input  logic [AW-1:0]    amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             in_ready_q, out_valid_q, busy_q;
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: if (in_valid) begin
            res_d   = a;
            dir_d   = dir;
            cnt_d   = amt;
            state_d = (amt == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            res_d   = dir_q ? (res_q >> 1) : (res_q << 1);
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == AW'(1)) ? DONE : SHIFT;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Status outputs are registered from the next state so they change
   // on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         res_q       <= '0;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         in_ready_q  <= state_d == IDLE;
         out_valid_q <= state_d == DONE;
         busy_q      <= state_d != IDLE;
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign y         = res_q;
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (power of two, at least 2).
REQ-002 The block SHALL have parameter AW, default 3, giving the shift-amount width; AW SHALL equal log2(WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the request on a/dir/amt is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a request.
REQ-007 The block SHALL have port a, input, WIDTH bits, the operand.
REQ-008 The block SHALL have port dir, input, 1 bit: 0 = shift left, 1 = shift right.
REQ-009 The block SHALL have port amt, input, AW bits, the shift amount (0..WIDTH-1).
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning y holds a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes y.
REQ-012 The block SHALL have port y, output, WIDTH bits, the shifted result.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-016 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; a, dir and amt are latched on that edge.
REQ-017 On acceptance with amt=0, the next state SHALL be DONE with the result register equal to a.
REQ-018 On acceptance with amt>0, the next state SHALL be SHIFT, with the remaining count equal to amt.
REQ-019 Each SHIFT cycle SHALL shift the result register by exactly one bit in the latched direction, zero-fill, and decrement the count.
REQ-020 When the count goes from 1 to 0, the next state SHALL be DONE.
REQ-021 Latency SHALL be fixed: out_valid rises amt+1 cycles after the accepting edge (1 cycle when amt=0).
REQ-022 The operation SHALL be logical: no rotation and no sign extension; bits shifted out are discarded.
REQ-023 In DONE, out_valid SHALL be 1 and y SHALL hold the result stable until the handshake completes.
REQ-024 A DONE cycle with out_ready=1 SHALL complete the handshake; the next state is IDLE.
REQ-025 While out_ready=0 in DONE, the block SHALL remain in DONE indefinitely (backpressure), with y unchanged.
REQ-026 Input changes on a/dir/amt/in_valid outside an accepting edge SHALL have no effect on an operation in progress.
REQ-027 A new request SHALL NOT be accepted in the cycle a result is consumed; the earliest next acceptance is the following cycle in IDLE.
REQ-028 In IDLE and SHIFT, out_valid SHALL be 0; y is don't-care outside DONE but SHALL equal the internal result register.

Reset
REQ-029 When rst_n=0 at a rising edge, the state SHALL become IDLE, with the result register and count cleared to 0.
REQ-030 Reset values SHALL be in_ready=1, out_valid=0, busy=0 and y=0.
REQ-031 Reset SHALL take precedence over any handshake in the same cycle, including mid-SHIFT and DONE; the in-flight result is discarded.

Verification
REQ-032 The bench SHALL check a=10101100, dir=0, amt=3, out_ready=1 -> out_valid 4 cycles after acceptance, y=01100000, one cycle of out_valid.
REQ-033 The bench SHALL check a=10101100, dir=1, amt=2 -> y=00101011 after 3 cycles; and amt=0, either dir -> y=10101100 after 1 cycle.
REQ-034 The bench SHALL check the extremes a=10101100, amt=7: dir=0 -> y=00000000, and dir=1 -> y=00000001, each after 8 cycles.
REQ-035 The bench SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and y held; in_valid=1 meanwhile is not accepted (in_ready=0).
REQ-036 The bench SHALL check reset mid-SHIFT: rst_n=0 for 1 cycle during amt=7 -> next cycle IDLE, out_valid=0, y=0, in_ready=1.
REQ-037 The bench SHALL check back-to-back requests: in_valid held high across completion -> second acceptance one cycle after the DONE handshake, with a correct second result.
